// File: rtl/fifo_wr_stream_ctrl_if.sv
// Upstream valid/ready packet stream feeding the FIFO write controller.
// The master drives words; the slave (controller) returns ready.
interface fifo_wr_stream_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  s_ready;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/fifo_wr_stream_ctrl.sv
// Write-domain feeder for the async FIFO: 2-entry skid buffer, credit-gated writes,
// packet-boundary throttling on almost-full, status counters and sticky overflow.
module fifo_wr_stream_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int AFULL_RST  = 28,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  wclk,
  input  logic                  sw_rst,
  fifo_wr_stream_ctrl_if.slave  s_if,
  input  logic [4:0]            cfg_afull,
  input  logic                  cfg_throttle_en,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  write_enable,
  output logic [4:0]            afull_value,
  input  logic                  wfull,
  input  logic                  wr_almost_ful,
  input  logic                  overflow,
  input  logic [5:0]            wr_level,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  ovf_seen
);

  localparam int         SKID_DEPTH = 2;
  localparam logic [6:0] DEPTH_W    = 7'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PKT,
    ST_HOLD
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_buf_data [SKID_DEPTH];
  logic                  r_buf_last [SKID_DEPTH];
  logic [1:0]            r_count;
  logic                  r_s_ready;
  logic                  r_wr_last;

  logic [DATA_WIDTH-1:0] w_shift_data [SKID_DEPTH];
  logic                  w_shift_last [SKID_DEPTH];
  logic                  w_throttle;
  logic [6:0]            w_credit_sum;
  logic                  w_credit_ok;
  logic                  w_fsm_permit;
  logic                  w_issue;
  logic                  w_accept;
  logic [1:0]            w_count_next;
  logic [1:0]            w_wr_idx;

  assign s_if.s_ready = r_s_ready;

  assign w_throttle   = cfg_throttle_en && wr_almost_ful;
  // Count the write already in flight so a level one short of full cannot be overrun.
  assign w_credit_sum = {1'b0, wr_level} + {6'd0, write_enable};
  assign w_credit_ok  = (w_credit_sum < DEPTH_W);

  always_comb begin
    w_fsm_permit = 1'b0;
    case (r_state)
      ST_IDLE: w_fsm_permit = !w_throttle;
      ST_PKT:  w_fsm_permit = 1'b1;
      default: w_fsm_permit = 1'b0;
    endcase
  end

  assign w_issue      = (r_count != 2'd0) && !wfull && w_credit_ok && w_fsm_permit;
  assign w_accept     = s_if.s_valid && r_s_ready;
  assign w_count_next = r_count + {1'b0, w_accept} - {1'b0, w_issue};
  assign w_wr_idx     = r_count - {1'b0, w_issue};

  // Each entry's shift source is its successor; the tail has none.
  for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_shift
    if (gi < SKID_DEPTH - 1) begin : g_mid
      assign w_shift_data[gi] = r_buf_data[gi+1];
      assign w_shift_last[gi] = r_buf_last[gi+1];
    end else begin : g_tail
      assign w_shift_data[gi] = '0;
      assign w_shift_last[gi] = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    for (int i = 0; i < SKID_DEPTH; i++) begin
      if (w_accept && (w_wr_idx == 2'(i))) begin
        r_buf_data[i] <= s_if.s_data;
        r_buf_last[i] <= s_if.s_last;
      end else if (w_issue) begin
        r_buf_data[i] <= w_shift_data[i];
        r_buf_last[i] <= w_shift_last[i];
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (sw_rst) begin
      r_state      <= ST_IDLE;
      r_count      <= 2'd0;
      r_s_ready    <= 1'b0;
      r_wr_last    <= 1'b0;
      write_enable <= 1'b0;
      wdata        <= '0;
      afull_value  <= 5'(AFULL_RST);
      word_count   <= '0;
      pkt_count    <= '0;
      ovf_seen     <= 1'b0;
    end else begin
      r_count      <= w_count_next;
      r_s_ready    <= (w_count_next < 2'd2);
      write_enable <= w_issue;
      r_wr_last    <= w_issue && r_buf_last[0];
      if (w_issue) begin
        wdata <= r_buf_data[0];
      end
      afull_value <= cfg_afull;
      ovf_seen    <= ovf_seen | overflow;
      if (write_enable) begin
        word_count <= word_count + CNT_WIDTH'(1);
        if (r_wr_last) begin
          pkt_count <= pkt_count + CNT_WIDTH'(1);
        end
      end

      // Throttle is only honoured between packets so a started packet always completes.
      case (r_state)
        ST_IDLE: begin
          if (w_throttle) begin
            r_state <= ST_HOLD;
          end else if (w_issue && !r_buf_last[0]) begin
            r_state <= ST_PKT;
          end
        end
        ST_PKT: begin
          if (w_issue && r_buf_last[0]) begin
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!w_throttle) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
